// File: rtl/sram_rr_arbiter.sv
// Two-client round-robin arbiter in front of the single-port sram_wrapper.
// Registers the command, lines write data up with the wrapper's data register, and tags reads for a fixed-latency return.
module sram_rr_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wmode,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wmode,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle
);

  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              sel_wmode;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        pipe_v;
  logic [2:0]        pipe_id;

  // prio names the client that wins when both are valid
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    sel_wmode = 1'b0;
    sel_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      grant0 = req0_valid & (~req1_valid | ~prio);
      grant1 = req1_valid & (~req0_valid | prio);
    end
    if (grant1) begin
      sel_wmode = req1_wmode;
      sel_addr  = req1_addr;
      if (req1_wmode) mem_wdata = req1_wdata;
    end else if (grant0) begin
      sel_wmode = req0_wmode;
      sel_addr  = req0_addr;
      if (req0_wmode) mem_wdata = req0_wdata;
    end
  end

  assign grant_any  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wmode <= 1'b0;
      mem_addr  <= '0;
      pipe_v    <= '0;
      pipe_id   <= '0;
    end else begin
      if (grant0) begin
        prio <= 1'b1;
      end else if (grant1) begin
        prio <= 1'b0;
      end
      mem_en <= grant_any;
      if (grant_any) begin
        mem_wmode <= sel_wmode;
        mem_addr  <= sel_addr;
      end
      // stage 2 lines up with the wrapper's registered read data
      pipe_v  <= {pipe_v[1:0], grant_any & ~sel_wmode};
      pipe_id <= {pipe_id[1:0], grant1};
    end
  end

  always_comb begin
    rsp0_valid = pipe_v[2] & ~pipe_id[2] & ~rst;
    rsp1_valid = pipe_v[2] & pipe_id[2] & ~rst;
    rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    rsp1_rdata = rsp1_valid ? mem_rdata : '0;
  end

  assign idle = ~req0_valid & ~req1_valid & ~mem_en & ~(|pipe_v);

endmodule
